bus_control_unit: RTL

- Microsequencer that drives the datapath bus selector and register write strobes of the matrix-multiplication processor.
- Each cycle it chooses one bus source (read_en code), one destination (write_en code), plus increment, ALU and data-memory strobes.
- It fetches 16-bit instructions from instruction memory via PC→AR→IR, decodes them, and sequences multi-cycle transfers until END.

---
 rtl/bus_control_unit.sv | 137 +++++++++++++
 1 files changed

// File: rtl/bus_control_unit.sv
// Microsequencer for the matrix-multiplication processor datapath.
// Fetches via PC->AR->IR, decodes, and strobes bus source/destination selects.
module bus_control_unit #(
    parameter int OPW    = 4,
    parameter int SELW   = 5,
    parameter int DM_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [15:0]     ir_in,
    input  logic            z_flag,
    output logic [SELW-1:0] read_en,
    output logic [SELW-1:0] write_en,
    output logic [4:0]      inc_en,
    output logic [1:0]      alu_op,
    output logic            dm_we,
    output logic            busy,
    output logic            done
);

    typedef enum logic [3:0] {
        S_IDLE, S_F_ADDR, S_F_WAIT, S_F_LOAD, S_DECODE,
        S_EX1, S_EX_WAIT, S_EX2, S_DONE
    } state_t;

    localparam logic [OPW-1:0] OP_MOV = OPW'(1);
    localparam logic [OPW-1:0] OP_LD  = OPW'(2);
    localparam logic [OPW-1:0] OP_ST  = OPW'(3);
    localparam logic [OPW-1:0] OP_ADD = OPW'(4);
    localparam logic [OPW-1:0] OP_MAC = OPW'(5);
    localparam logic [OPW-1:0] OP_INC = OPW'(6);
    localparam logic [OPW-1:0] OP_CLR = OPW'(7);
    localparam logic [OPW-1:0] OP_JMP = OPW'(8);
    localparam logic [OPW-1:0] OP_JNZ = OPW'(9);
    localparam logic [OPW-1:0] OP_END = OPW'(15);
    localparam logic [1:0]     CNT_LAST = 2'(DM_LAT - 1);

    state_t          r_state;
    logic [1:0]      r_cnt;
    logic [OPW-1:0]  w_op;
    logic [SELW-1:0] w_src;
    logic [SELW-1:0] w_dst;
    logic            w_unused;

    assign w_op     = ir_in[15:16-OPW];
    assign w_src    = SELW'(ir_in[9:5]);
    assign w_dst    = SELW'(ir_in[4:0]);
    assign w_unused = &{1'b0, ir_in[11:10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE:   if (start) r_state <= S_F_ADDR;
                S_F_ADDR: r_state <= S_F_WAIT;
                S_F_WAIT: r_state <= S_F_LOAD;
                S_F_LOAD: r_state <= S_DECODE;
                S_DECODE: r_state <= (w_op == OP_END) ? S_DONE : S_EX1;
                S_EX1: begin
                    r_cnt <= '0;
                    r_state <= (w_op == OP_LD) ? S_EX_WAIT : S_F_ADDR;
                end
                S_EX_WAIT: begin
                    if (r_cnt == CNT_LAST) r_state <= S_EX2;
                    else r_cnt <= r_cnt + 2'd1;
                end
                S_EX2:    r_state <= S_F_ADDR;
                S_DONE:   if (start) r_state <= S_F_ADDR;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        read_en  = '0;
        write_en = '0;
        inc_en   = '0;
        alu_op   = '0;
        dm_we    = 1'b0;
        busy     = (r_state != S_IDLE) && (r_state != S_DONE);
        done     = (r_state == S_DONE);
        case (r_state)
            S_F_ADDR: begin
                read_en  = SELW'(13);
                write_en = SELW'(11);
            end
            S_F_LOAD: begin
                read_en  = SELW'(15);
                write_en = SELW'(12);
                inc_en   = 5'b10000;
            end
            S_EX1: begin
                case (w_op)
                    OP_MOV: begin
                        read_en  = w_src;
                        write_en = w_dst;
                    end
                    OP_LD: begin
                        read_en  = w_src;
                        write_en = SELW'(11);
                    end
                    OP_ST: begin
                        read_en = w_src;
                        dm_we   = 1'b1;
                    end
                    OP_ADD, OP_MAC: begin
                        read_en  = w_src;
                        write_en = SELW'(14);
                        alu_op   = (w_op == OP_ADD) ? 2'd1 : 2'd2;
                    end
                    OP_INC: inc_en = ir_in[4:0];
                    OP_CLR: begin
                        write_en = SELW'(14);
                        alu_op   = 2'd3;
                    end
                    OP_JMP, OP_JNZ: begin
                        // JNZ falls through to a no-op when AC is zero
                        if (w_op == OP_JMP || !z_flag) begin
                            read_en  = SELW'(1);
                            write_en = SELW'(13);
                        end
                    end
                    default: ;
                endcase
            end
            S_EX2: begin
                read_en  = SELW'(16);
                write_en = w_dst;
            end
            default: ;
        endcase
    end

endmodule
